// File: rtl/clkgt_pkg.sv
// Shared types for the hysteresis clock-gating controller.
package clkgt_pkg;

   typedef enum logic [1:0] {CG_ON, CG_DRAIN, CG_OFF, CG_WAKE} cg_state_e;

   localparam cg_state_e CG_RESET_STATE = CG_ON;

   function automatic logic cg_is_ready(input cg_state_e s);
      return (s == CG_ON) || (s == CG_DRAIN);
   endfunction

endpackage

// File: rtl/clkgt_chan.sv
// One gated clock channel: idle-hysteresis FSM, hold counter and glitch-free gate.
// The gated-cycle counter is present only when CLKGT_STATS_EN is defined.
module clkgt_chan
   import clkgt_pkg::*;
#(
   parameter int HOLD_W = 8
`ifdef CLKGT_STATS_EN
   , parameter int STAT_W = 16
`endif
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_te,
   input  logic              i_busy,
   input  logic              i_wake,
   input  logic              i_force_on,
   input  logic [HOLD_W-1:0] i_hold_cycles,
   output logic              o_gclk,
   output logic              o_ready,
   output logic              o_gated
`ifdef CLKGT_STATS_EN
   , output logic [STAT_W-1:0] o_gcnt
`endif
);

   cg_state_e         r_state;
   cg_state_e         w_state_nxt;
   logic [HOLD_W-1:0] r_cnt;
   logic [HOLD_W-1:0] w_cnt_nxt;
   logic              w_any;
   logic              w_en;
   logic              r_ready;
   logic              r_gated;

   assign w_any = i_busy | i_wake | i_force_on;
   // te only forces the enable; the FSM never sees it.
   assign w_en  = (r_state != CG_OFF) | i_te;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         CG_ON: begin
            if (!w_any) begin
               w_state_nxt = CG_DRAIN;
               w_cnt_nxt   = i_hold_cycles;
            end else begin
               w_state_nxt = CG_ON;
            end
         end
         CG_DRAIN: begin
            if (w_any) begin
               w_state_nxt = CG_ON;
            end else if (r_cnt == {HOLD_W{1'b0}}) begin
               w_state_nxt = CG_OFF;
            end else begin
               w_cnt_nxt = r_cnt - HOLD_W'(1);
            end
         end
         CG_OFF: begin
            if (w_any) begin
               w_state_nxt = CG_WAKE;
            end else begin
               w_state_nxt = CG_OFF;
            end
         end
         CG_WAKE: w_state_nxt = CG_ON;
         default: w_state_nxt = CG_RESET_STATE;
      endcase
   end

   // Status flags decode the next state so they change on the same edge as the FSM.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= CG_RESET_STATE;
         r_cnt   <= {HOLD_W{1'b0}};
         r_ready <= 1'b1;
         r_gated <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= cg_is_ready(w_state_nxt);
         r_gated <= (w_state_nxt == CG_OFF);
      end
   end

   assign o_ready = r_ready;
   assign o_gated = r_gated;

`ifdef SYNTHESIS
   // Target-library integrated clock gate; reset holds the clock running.
   clkgt_icg_cell u_icg (
      .CK (i_clock),
      .E  (w_en | i_reset),
      .TE (1'b0),
      .Q  (o_gclk)
   );
`else
   logic r_en_q;

   always_latch begin
      if (i_reset) begin
         r_en_q <= 1'b1;
      end else if (!i_clock) begin
         r_en_q <= w_en;
      end
   end

   assign o_gclk = i_clock & r_en_q;
`endif

`ifdef CLKGT_STATS_EN
   logic [STAT_W-1:0] r_gcnt;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_gcnt <= {STAT_W{1'b0}};
      end else if ((r_state == CG_OFF) && (r_gcnt != {STAT_W{1'b1}})) begin
         r_gcnt <= r_gcnt + STAT_W'(1);
      end
   end

   assign o_gcnt = r_gcnt;
`endif

endmodule

// File: rtl/clkgt_hyst_ctrl.sv
// Multi-channel clock-gating controller with idle hysteresis.
// Define CLKGT_STATS_EN to add the per-channel gated-cycle counters (ch_gcnt).
module clkgt_hyst_ctrl
   import clkgt_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int HOLD_W = 8
`ifdef CLKGT_STATS_EN
   , parameter int STAT_W = 16
`endif
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              te,
   input  logic [NUM_CH-1:0] ch_busy,
   input  logic [NUM_CH-1:0] ch_wake,
   input  logic [NUM_CH-1:0] ch_force_on,
   input  logic [HOLD_W-1:0] hold_cycles,
   output logic [NUM_CH-1:0] gclk,
   output logic [NUM_CH-1:0] ch_ready,
   output logic [NUM_CH-1:0] ch_gated
`ifdef CLKGT_STATS_EN
   , output logic [NUM_CH*STAT_W-1:0] ch_gcnt
`endif
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clkgt_chan #(
         .HOLD_W (HOLD_W)
`ifdef CLKGT_STATS_EN
         , .STAT_W (STAT_W)
`endif
      ) u_chan (
         .i_clock       (clock),
         .i_reset       (reset),
         .i_te          (te),
         .i_busy        (ch_busy[g]),
         .i_wake        (ch_wake[g]),
         .i_force_on    (ch_force_on[g]),
         .i_hold_cycles (hold_cycles),
         .o_gclk        (gclk[g]),
         .o_ready       (ch_ready[g]),
         .o_gated       (ch_gated[g])
`ifdef CLKGT_STATS_EN
         , .o_gcnt      (ch_gcnt[g*STAT_W +: STAT_W])
`endif
      );
   end

endmodule

// File: tb/tb_clkgt_hyst_ctrl.sv
// Bench for clkgt_hyst_ctrl: vector table, directed corner sequences and random
// stimulus checked against an idle-run-length model of the gating rules.
module tb_clkgt_hyst_ctrl;
   localparam int NUM_CH = 4;
   localparam int HOLD_W = 8;
`ifdef CLKGT_STATS_EN
   localparam int STAT_W = 4;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              te = 1'b0;
   logic [NUM_CH-1:0] ch_busy = '0;
   logic [NUM_CH-1:0] ch_wake = '0;
   logic [NUM_CH-1:0] ch_force_on = '0;
   logic [HOLD_W-1:0] hold_cycles = '0;
   logic [NUM_CH-1:0] gclk;
   logic [NUM_CH-1:0] ch_ready;
   logic [NUM_CH-1:0] ch_gated;
`ifdef CLKGT_STATS_EN
   logic [NUM_CH*STAT_W-1:0] ch_gcnt;
`endif

   always #5 clock = ~clock;

   clkgt_hyst_ctrl #(
      .NUM_CH (NUM_CH),
      .HOLD_W (HOLD_W)
`ifdef CLKGT_STATS_EN
      , .STAT_W (STAT_W)
`endif
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .te          (te),
      .ch_busy     (ch_busy),
      .ch_wake     (ch_wake),
      .ch_force_on (ch_force_on),
      .hold_cycles (hold_cycles),
      .gclk        (gclk),
      .ch_ready    (ch_ready),
      .ch_gated    (ch_gated)
`ifdef CLKGT_STATS_EN
      , .ch_gcnt   (ch_gcnt)
`endif
   );

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Model: phase 0 = clock running, 1 = stopped, 2 = waking.
   // A running channel stops once it has seen hold+2 consecutive idle samples.
   int m_phase[NUM_CH];
   int m_idle[NUM_CH];
   int m_hold[NUM_CH];
   int m_gcnt[NUM_CH];

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_phase[c] = 0;
         m_idle[c]  = 0;
         m_hold[c]  = 0;
         m_gcnt[c]  = 0;
      end
   endtask

   function automatic logic [NUM_CH-1:0] model_en();
      logic [NUM_CH-1:0] e;
      for (int c = 0; c < NUM_CH; c++) e[c] = (m_phase[c] != 1) || te;
      return e;
   endfunction

   task automatic model_edge();
      for (int c = 0; c < NUM_CH; c++) begin
         logic any;
         any = ch_busy[c] | ch_wake[c] | ch_force_on[c];
`ifdef CLKGT_STATS_EN
         if (m_phase[c] == 1 && m_gcnt[c] < (1 << STAT_W) - 1) m_gcnt[c]++;
`endif
         if (m_phase[c] == 0) begin
            if (any) begin
               m_idle[c] = 0;
            end else begin
               if (m_idle[c] == 0) m_hold[c] = int'(hold_cycles);
               m_idle[c]++;
               if (m_idle[c] == m_hold[c] + 2) begin
                  m_phase[c] = 1;
                  m_idle[c]  = 0;
               end
            end
         end else if (m_phase[c] == 1) begin
            if (any) m_phase[c] = 2;
         end else begin
            m_phase[c] = 0;
            m_idle[c]  = 0;
         end
      end
   endtask

   function automatic logic [NUM_CH-1:0] exp_ready();
      logic [NUM_CH-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c] = (m_phase[c] == 0);
      return r;
   endfunction

   function automatic logic [NUM_CH-1:0] exp_gated();
      logic [NUM_CH-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c] = (m_phase[c] == 1);
      return r;
   endfunction

   // One clock edge: predict, advance model, sample mid high phase, compare.
   task automatic step(input string tag);
      logic [NUM_CH-1:0] en_exp;
      en_exp = model_en();
      model_edge();
      @(posedge clock);
      #2;
      check({tag, "/gclk"}, 32'(gclk), 32'(en_exp));
      check({tag, "/ready"}, 32'(ch_ready), 32'(exp_ready()));
      check({tag, "/gated"}, 32'(ch_gated), 32'(exp_gated()));
`ifdef CLKGT_STATS_EN
      begin
         logic [NUM_CH*STAT_W-1:0] g;
         for (int c = 0; c < NUM_CH; c++) g[c*STAT_W +: STAT_W] = STAT_W'(m_gcnt[c]);
         check({tag, "/gcnt"}, 32'(ch_gcnt), 32'(g));
      end
`endif
   endtask

   typedef struct {
      logic              busy;
      logic              wake;
      logic              force_on;
      logic              te;
      logic [HOLD_W-1:0] hold;
      logic              ready;
      logic              gated;
      logic              gclk;
   } vec_t;

   vec_t vecs[18];

   initial begin
      int found;

      //            busy  wake  force te    hold   ready gated gclk
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};

      // Reset state: clocks run, all ready, none gated.
      @(posedge clock);
      #2;
      check("rst/gclk", 32'(gclk), 32'({NUM_CH{1'b1}}));
      check("rst/ready", 32'(ch_ready), 32'({NUM_CH{1'b1}}));
      check("rst/gated", 32'(ch_gated), 32'(0));
`ifdef CLKGT_STATS_EN
      check("rst/gcnt", 32'(ch_gcnt), 32'(0));
`endif
      @(negedge clock);
      reset = 1'b0;
      model_reset();

      for (int i = 0; i < 18; i++) begin
         ch_busy     = {NUM_CH{vecs[i].busy}};
         ch_wake     = {NUM_CH{vecs[i].wake}};
         ch_force_on = {NUM_CH{vecs[i].force_on}};
         te          = vecs[i].te;
         hold_cycles = vecs[i].hold;
         @(posedge clock);
         #2;
         check($sformatf("vec%0d/gclk", i), 32'(gclk), 32'({NUM_CH{vecs[i].gclk}}));
         check($sformatf("vec%0d/ready", i), 32'(ch_ready), 32'({NUM_CH{vecs[i].ready}}));
         check($sformatf("vec%0d/gated", i), 32'(ch_gated), 32'({NUM_CH{vecs[i].gated}}));
      end

      ch_busy = '0; ch_wake = '0; ch_force_on = '0; te = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();

      // Hold expiry with H=3: DRAIN at the drop edge, OFF four edges later.
      hold_cycles = 8'd3;
      ch_busy = '1;
      step("t1_busy");
      step("t1_busy");
      ch_busy = '0;
      for (int k = 0; k < 6; k++) begin
         step("t1_drain");
         check($sformatf("t1_gated_k%0d", k), 32'(ch_gated[0]), 32'(k >= 4));
         check($sformatf("t1_gclk_k%0d", k), 32'(gclk[0]), 32'(k <= 4));
      end

      // Test enable forces the clocks while the FSMs stay gated.
      te = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step("t5_te");
         check("t5_te_gclk", 32'(gclk), 32'({NUM_CH{1'b1}}));
         check("t5_te_gated", 32'(ch_gated), 32'({NUM_CH{1'b1}}));
      end
      te = 1'b0;
      step("t5_te_off");

      // Wake latency on channel 0 only.
      ch_wake = 4'b0001;
      step("t3_wake");
      check("t3_wake_ready", 32'(ch_ready[0]), 32'(0));
      check("t3_wake_gated", 32'(ch_gated[0]), 32'(0));
      check("t3_wake_gclk", 32'(gclk[0]), 32'(0));
      ch_wake = '0;
      step("t3_on");
      check("t3_on_ready", 32'(ch_ready[0]), 32'(1));
      check("t3_on_gclk", 32'(gclk[0]), 32'(1));
      check("t3_others_gated", 32'(ch_gated[3:1]), 32'(3'b111));

      // Re-activate mid-drain with H=5, then a fresh drop reloads the hold.
      ch_busy = '1;
      step("t2_busy");
      hold_cycles = 8'd5;
      ch_busy = '0;
      step("t2_drop");
      step("t2_drain");
      ch_busy = '1;
      step("t2_reactivate");
      check("t2_ready", 32'(ch_ready), 32'({NUM_CH{1'b1}}));
      ch_busy = '0;
      found = -1;
      for (int k = 0; k < 20; k++) begin
         step("t2_redrain");
         if (ch_gated[0] && found < 0) found = k;
      end
      check("t2_reload_edges", 32'(found), 32'(6));

      // Busy arriving on the cnt==0 drain cycle wins over expiry (H=2).
      ch_busy = '1;
      step("t4_busy");
      step("t4_busy");
      hold_cycles = 8'd2;
      ch_busy = '0;
      step("t4_d2");
      step("t4_d1");
      step("t4_d0");
      ch_busy = '1;
      step("t4_prio");
      check("t4_prio_gated", 32'(ch_gated), 32'(0));
      check("t4_prio_ready", 32'(ch_ready), 32'({NUM_CH{1'b1}}));

      // Reset while gated; with stats, dwell long enough to saturate.
      ch_busy = '0;
      hold_cycles = 8'd0;
      for (int k = 0; k < 22; k++) step("t6_idle");
`ifdef CLKGT_STATS_EN
      check("t6_gcnt_sat", 32'(ch_gcnt), 32'({NUM_CH{4'hF}}));
`endif
      #1;
      reset = 1'b1;
      #1;
      check("t6_rst_ready", 32'(ch_ready), 32'({NUM_CH{1'b1}}));
      check("t6_rst_gated", 32'(ch_gated), 32'(0));
      @(posedge clock);
      #2;
      check("t6_rst_gclk", 32'(gclk), 32'({NUM_CH{1'b1}}));
`ifdef CLKGT_STATS_EN
      check("t6_rst_gcnt", 32'(ch_gcnt), 32'(0));
`endif
      @(negedge clock);
      reset = 1'b0;
      model_reset();

      // Random traffic; channel 1 is forced on for the first half.
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ch_busy[c]     = ($urandom_range(0, 5) == 0);
            ch_wake[c]     = ($urandom_range(0, 15) == 0);
            ch_force_on[c] = (c == 1) ? (n < 200) : 1'b0;
         end
         te = ($urandom_range(0, 31) == 0);
         if (n % 50 == 0) hold_cycles = HOLD_W'($urandom_range(0, 6));
         step("rand");
         if (n < 200) check("rand_force_ch1", 32'(ch_gated[1]), 32'(0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
